// File: rtl/uart_tx_valid_ready.sv
// UART transmitter fed by a valid/ready word stream.
// One frame per accepted word; up_ready stays low for the whole frame.
module uart_tx_valid_ready #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int WIDTH     = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             tx,
  output logic             busy
);

  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int STOP_CLKS = STOP_BITS * CPB;
  localparam int CW        = $clog2(STOP_CLKS);
  localparam int BW        = $clog2(WIDTH + 1);

  if (CPB < 2) begin : g_cpb_chk
    $error("CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    baud, baud_n;
  logic [BW-1:0]    bits, bits_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic             par_bit, par_n;
  logic             tx_n, ready_n, busy_n;
  logic             bit_end;

  assign bit_end = (baud == CW'(CPB - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state    <= S_IDLE;
      baud     <= '0;
      bits     <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      up_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bits     <= bits_n;
      shift    <= shift_n;
      par_bit  <= par_n;
      tx       <= tx_n;
      up_ready <= ready_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bits_n  = bits;
    shift_n = shift;
    par_n   = par_bit;
    tx_n    = tx;
    ready_n = up_ready;
    busy_n  = busy;
    unique case (state)
      S_IDLE: begin
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
        if (up_valid && up_ready) begin
          shift_n = up_data;
          par_n   = (PARITY == 2) ? ~^up_data : ^up_data;
          baud_n  = '0;
          bits_n  = '0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
          tx_n    = 1'b0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_n  = '0;
          tx_n    = shift[0];
          state_n = S_DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bits == BW'(WIDTH - 1)) begin
            if (PARITY != 0) begin
              tx_n    = par_bit;
              state_n = S_PAR;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            bits_n  = bits + 1'b1;
            shift_n = shift >> 1;
            tx_n    = shift_n[0];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_PAR: begin
        if (bit_end) begin
          baud_n  = '0;
          tx_n    = 1'b1;
          state_n = S_STOP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      S_STOP: begin
        // all stop bits share one count so 8N2 is a single long high
        if (baud == CW'(STOP_CLKS - 1)) begin
          baud_n  = '0;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
